// File: rtl/intest_response_misr.sv
// INTEST response analyser: compacts the wrapper output into a MISR signature on each
// rising edge of done, then checks it against a golden value or flags a watchdog timeout.
module intest_response_misr #(
   parameter int             W       = 66,
   parameter int             N_PAT   = 16,
   parameter logic [W-1:0]   POLY    = 66'h0000000000000002D,
   parameter int             TIMEOUT = 1024
) (
   input  logic                         cirCLK,
   input  logic                         cirRST,
   input  logic                         armIn,
   input  logic [W-1:0]                 dutOut,
   input  logic [W-1:0]                 expSig,
   output logic [W-1:0]                 sigOut,
   output logic [$clog2(N_PAT+1)-1:0]   patCount,
   output logic                         busy,
   output logic                         finished,
   output logic                         pass,
   output logic                         fail,
   output logic                         timeout
);

   localparam int CW = $clog2(N_PAT + 1);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [CW-1:0] PAT_LAST = CW'(N_PAT - 1);
   localparam logic [CW-1:0] PAT_MAX  = CW'(N_PAT);
   localparam logic [TW-1:0] WD_MAX   = TW'(TIMEOUT - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_CAPTURE = 2'd1;
   localparam logic [1:0] S_COMPARE = 2'd2;
   localparam logic [1:0] S_REPORT  = 2'd3;

   logic [1:0]    state_q,   state_d;
   logic [W-1:0]  sig_q,     sig_d;
   logic [CW-1:0] pat_q,     pat_d;
   logic [TW-1:0] wd_q,      wd_d;
   logic          pass_q,    pass_d;
   logic          fail_q,    fail_d;
   logic          timeout_q, timeout_d;
   logic          done_q;
   logic          cap;
   logic [W-1:0]  misr_next;

   // A restart on armIn wins over a coincident done edge, so that edge is never compacted.
   assign cap       = (state_q == S_CAPTURE) & dutOut[0] & ~done_q & ~armIn;
   assign misr_next = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ dutOut;

   always_comb begin
      state_d   = state_q;
      sig_d     = sig_q;
      pat_d     = pat_q;
      wd_d      = wd_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      timeout_d = timeout_q;

      if (armIn) begin
         state_d   = S_CAPTURE;
         sig_d     = '0;
         pat_d     = '0;
         wd_d      = '0;
         pass_d    = 1'b0;
         fail_d    = 1'b0;
         timeout_d = 1'b0;
      end else begin
         case (state_q)
            S_CAPTURE: begin
               if (cap) begin
                  sig_d = misr_next;
                  wd_d  = '0;
                  if (pat_q != PAT_MAX) begin
                     pat_d = pat_q + 1'b1;
                  end
                  if (pat_q == PAT_LAST) begin
                     state_d = S_COMPARE;
                  end
               end else if (wd_q == WD_MAX) begin
                  state_d   = S_REPORT;
                  timeout_d = 1'b1;
                  fail_d    = 1'b1;
                  pass_d    = 1'b0;
               end else begin
                  wd_d = wd_q + 1'b1;
               end
            end
            S_COMPARE: begin
               pass_d  = (sig_q == expSig);
               fail_d  = (sig_q != expSig);
               state_d = S_REPORT;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge cirCLK or negedge cirRST) begin
      if (!cirRST) begin
         state_q   <= S_IDLE;
         sig_q     <= '0;
         pat_q     <= '0;
         wd_q      <= '0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
         timeout_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sig_q     <= sig_d;
         pat_q     <= pat_d;
         wd_q      <= wd_d;
         pass_q    <= pass_d;
         fail_q    <= fail_d;
         timeout_q <= timeout_d;
         done_q    <= dutOut[0];
      end
   end

   assign sigOut   = sig_q;
   assign patCount = pat_q;
   assign busy     = (state_q == S_CAPTURE) | (state_q == S_COMPARE);
   assign finished = (state_q == S_REPORT);
   assign pass     = pass_q;
   assign fail     = fail_q;
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_intest_response_misr.sv
// Scoreboard bench: a small-session instance (N_PAT=2, TIMEOUT=8) checked through a report
// queue, plus a default-parameter instance for held-done and MISR feedback behaviour.
module tb_intest_response_misr;

   typedef struct packed {
      logic        pass_v;
      logic        fail_v;
      logic        timeout_v;
      logic [65:0] sig_v;
   } exp_t;

   logic        cir_clk;
   logic        cir_rst;

   logic        arm_a;
   logic [65:0] dut_out_a;
   logic [65:0] exp_sig_a;
   logic [65:0] sig_a;
   logic [1:0]  pat_a;
   logic        busy_a, finished_a, pass_a, fail_a, timeout_a;

   logic        arm_b;
   logic [65:0] dut_out_b;
   logic [65:0] exp_sig_b;
   logic [65:0] sig_b;
   logic [4:0]  pat_b;
   logic        busy_b, finished_b, pass_b, fail_b, timeout_b;

   exp_t        sb_q[$];
   int          tests_run    = 0;
   int          fail_count   = 0;
   int          reports_seen = 0;
   logic        fin_prev     = 1'b0;

   intest_response_misr #(.W(66), .N_PAT(2), .POLY(66'h0000000000000002D), .TIMEOUT(8)) u_dut_a (
      .cirCLK(cir_clk), .cirRST(cir_rst), .armIn(arm_a), .dutOut(dut_out_a), .expSig(exp_sig_a),
      .sigOut(sig_a), .patCount(pat_a), .busy(busy_a), .finished(finished_a),
      .pass(pass_a), .fail(fail_a), .timeout(timeout_a)
   );

   intest_response_misr u_dut_b (
      .cirCLK(cir_clk), .cirRST(cir_rst), .armIn(arm_b), .dutOut(dut_out_b), .expSig(exp_sig_b),
      .sigOut(sig_b), .patCount(pat_b), .busy(busy_b), .finished(finished_b),
      .pass(pass_b), .fail(fail_b), .timeout(timeout_b)
   );

   initial begin
      cir_clk = 1'b0;
      forever #5 cir_clk = ~cir_clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got no end of test, expected end of test");
      $fatal(1, "[TB] simulation time limit exceeded");
   end

   task automatic checkOutput(input string name, input logic [65:0] act, input logic [65:0] exp_v);
      tests_run++;
      if (act !== exp_v) begin
         fail_count++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge cir_clk);
      #1;
   endtask

   // Drives one cycle of instance A inputs and advances past the next rising edge.
   task automatic applyStimulus(input logic arm, input logic [65:0] word);
      arm_a     = arm;
      dut_out_a = word;
      tick();
      arm_a     = 1'b0;
   endtask

   task automatic waitFinishedA(input string name);
      for (int i = 0; i < 20 && !finished_a; i++) tick();
      checkOutput(name, finished_a, 1'b1);
   endtask

   // Monitor: every rising edge of finished on instance A retires one scoreboard entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge cir_clk);
         if (finished_a && !fin_prev) begin
            reports_seen++;
            if (sb_q.size() == 0) begin
               checkOutput("sb_unexpected_report", 66'd1, 66'd0);
            end else begin
               e = sb_q.pop_front();
               checkOutput("sb_pass",    pass_a,    e.pass_v);
               checkOutput("sb_fail",    fail_a,    e.fail_v);
               checkOutput("sb_timeout", timeout_a, e.timeout_v);
               checkOutput("sb_sig",     sig_a,     e.sig_v);
            end
         end
         fin_prev = finished_a;
      end
   end

   initial begin
      cir_rst   = 1'b0;
      arm_a     = 1'b0;
      dut_out_a = '0;
      exp_sig_a = '0;
      arm_b     = 1'b0;
      dut_out_b = '0;
      exp_sig_b = '0;

      #3;
      checkOutput("rst_sig_a",  sig_a, 66'd0);
      checkOutput("rst_flags_a", {busy_a, finished_a, pass_a, fail_a, timeout_a}, 66'd0);
      checkOutput("rst_pat_a",  pat_a, 66'd0);
      checkOutput("rst_flags_b", {busy_b, finished_b, pass_b, fail_b, timeout_b}, 66'd0);
      #9;
      cir_rst = 1'b1;
      tick();

      // Good session: words 1 then 1 give signature 1 then 3.
      exp_sig_a = 66'h3;
      sb_q.push_back('{1'b1, 1'b0, 1'b0, 66'h3});
      applyStimulus(1'b1, 66'h0);
      checkOutput("arm_busy", busy_a, 1'b1);
      checkOutput("arm_pat", pat_a, 66'd0);
      applyStimulus(1'b0, 66'h1);
      checkOutput("good_sig1", sig_a, 66'h1);
      checkOutput("good_pat1", pat_a, 66'd1);
      applyStimulus(1'b0, 66'h0);
      applyStimulus(1'b0, 66'h1);
      checkOutput("good_sig2", sig_a, 66'h3);
      checkOutput("good_pat2", pat_a, 66'd2);
      applyStimulus(1'b0, 66'h0);
      waitFinishedA("good_finished");

      // Faulty second word 3: (1<<1)^3 = 1, mismatching golden 3.
      sb_q.push_back('{1'b0, 1'b1, 1'b0, 66'h1});
      applyStimulus(1'b1, 66'h0);
      checkOutput("rearm_clear", {finished_a, pass_a, fail_a, timeout_a}, 66'd0);
      applyStimulus(1'b0, 66'h1);
      applyStimulus(1'b0, 66'h0);
      applyStimulus(1'b0, 66'h3);
      checkOutput("bad_sig", sig_a, 66'h1);
      applyStimulus(1'b0, 66'h0);
      waitFinishedA("bad_finished");

      // Watchdog: no done at all, report lands on the 8th edge after the arm edge.
      sb_q.push_back('{1'b0, 1'b1, 1'b1, 66'h0});
      applyStimulus(1'b1, 66'h0);
      for (int i = 0; i < 7; i++) tick();
      checkOutput("wd_not_yet", finished_a, 1'b0);
      tick();
      checkOutput("wd_finished", finished_a, 1'b1);
      checkOutput("wd_timeout", timeout_a, 1'b1);
      checkOutput("wd_busy", busy_a, 1'b0);

      // Done already high at arm, then arm colliding with a done edge mid-session.
      exp_sig_a = 66'hB;
      sb_q.push_back('{1'b1, 1'b0, 1'b0, 66'hB});
      applyStimulus(1'b1, 66'h1);
      applyStimulus(1'b0, 66'h1);
      checkOutput("high_at_arm_pat", pat_a, 66'd0);
      applyStimulus(1'b0, 66'h0);
      applyStimulus(1'b0, 66'h5);
      checkOutput("pre_restart_pat", pat_a, 66'd1);
      applyStimulus(1'b0, 66'h0);
      applyStimulus(1'b1, 66'h1);
      checkOutput("restart_pat", pat_a, 66'd0);
      checkOutput("restart_sig", sig_a, 66'd0);
      checkOutput("restart_busy", busy_a, 1'b1);
      applyStimulus(1'b0, 66'h1);
      checkOutput("restart_held_pat", pat_a, 66'd0);
      applyStimulus(1'b0, 66'h0);
      applyStimulus(1'b0, 66'h5);
      applyStimulus(1'b0, 66'h0);
      applyStimulus(1'b0, 66'h1);
      checkOutput("restart_sig_final", sig_a, 66'hB);
      applyStimulus(1'b0, 66'h0);
      waitFinishedA("restart_finished");
      applyStimulus(1'b0, 66'h1);
      applyStimulus(1'b0, 66'h0);
      checkOutput("report_ignores_done_pat", pat_a, 66'd2);
      checkOutput("report_ignores_done_sig", sig_a, 66'hB);

      // Default instance: done held 10 cycles steps once; bit 65 then drives POLY feedback.
      arm_b = 1'b1;
      tick();
      arm_b     = 1'b0;
      dut_out_b = 66'h20000000000000001;
      repeat (10) tick();
      checkOutput("hold_pat", pat_b, 66'd1);
      checkOutput("hold_sig", sig_b, 66'h20000000000000001);
      dut_out_b = '0;
      tick();
      dut_out_b = 66'hF01;
      tick();
      dut_out_b = '0;
      checkOutput("feedback_sig", sig_b, 66'hF2E);
      checkOutput("feedback_pat", pat_b, 66'd2);

      // Asynchronous reset in the middle of a cycle during an active session.
      applyStimulus(1'b1, 66'h0);
      applyStimulus(1'b0, 66'h7);
      checkOutput("pre_reset_pat", pat_a, 66'd1);
      #2;
      cir_rst = 1'b0;
      #1;
      checkOutput("async_sig_a", sig_a, 66'd0);
      checkOutput("async_pat_a", pat_a, 66'd0);
      checkOutput("async_flags_a", {busy_a, finished_a, pass_a, fail_a, timeout_a}, 66'd0);
      checkOutput("async_sig_b", sig_b, 66'd0);
      checkOutput("async_busy_b", busy_b, 1'b0);
      @(negedge cir_clk);
      cir_rst = 1'b1;
      applyStimulus(1'b0, 66'h0);
      checkOutput("post_reset_idle", {busy_a, finished_a}, 66'd0);

      tick();
      checkOutput("sb_drain", 66'(sb_q.size()), 66'd0);
      checkOutput("reports_seen", 66'(reports_seen), 66'd4);

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
      $finish;
   end

endmodule
